// File: rtl/lab4d_pkg.sv
// Shared types and helpers for the LAB4D register sequencer: queued entry
// layout, sequencer FSM states, ACK timeout and the chip-select encoder.
package lab4d_pkg;

    localparam int NUM_LAB_DEF  = 12;
    localparam int DAT_W        = 24;
    localparam int ACK_TIMEOUT  = 4;

    typedef struct packed {
        logic [NUM_LAB_DEF-1:0] mask;
        logic [DAT_W-1:0]       dat;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_ACK,
        S_DONE,
        S_NEXT
    } state_t;

    // Scanning from the top down leaves the lowest set bit as the final winner.
    function automatic logic [3:0] lowest_set(input logic [15:0] mask);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lab4d_seq_fifo.sv
// First-word-fall-through FIFO holding queued register writes; a push while
// full is silently ignored, the parent does the overflow bookkeeping.
module lab4d_seq_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/lab4d_register_sequencer.sv
// Queues chip-masked LAB4D register writes and feeds them to the shift
// register one chip at a time, lowest chip index first, pacing on busy.
module lab4d_register_sequencer
    import lab4d_pkg::*;
#(
    parameter int NUM_LAB    = NUM_LAB_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_i,
    input  logic [DAT_W-1:0]            wr_dat_i,
    input  logic [NUM_LAB-1:0]          wr_mask_i,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        idle_o,
    output logic                        overflow_o,
    input  logic                        clr_ovf_i,
    output logic                        go_o,
    output logic [DAT_W-1:0]            dat_o,
    output logic [3:0]                  sel_o,
    input  logic                        busy_i
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT);

    state_t                 state;
    entry_t                 wr_entry;
    entry_t                 head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic [NUM_LAB_DEF-1:0] mask_r;
    logic [DAT_W-1:0]       dat_r;
    logic [NUM_LAB_DEF-1:0] issue_mask;
    logic [DAT_W-1:0]       issue_dat;
    logic [ACK_W-1:0]       ack_cnt;

    always_comb begin
        wr_entry.mask = NUM_LAB_DEF'(wr_mask_i);
        wr_entry.dat  = wr_dat_i;
    end

    lab4d_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (wr_i),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count_o)
    );

    assign pop    = (state == S_LOAD);
    assign full_o = fifo_full;
    assign idle_o = (state == S_IDLE) && fifo_empty && !busy_i;

    // A transfer launches from LOAD (fresh head) or NEXT (remaining mask);
    // select and data are registered on entry to ISSUE so go_o sees them.
    always_comb begin
        issue_mask = mask_r;
        issue_dat  = dat_r;
        if (state == S_LOAD) begin
            issue_mask = head.mask;
            issue_dat  = head.dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (wr_i && fifo_full) begin
            overflow_o <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            go_o    <= 1'b0;
            dat_o   <= '0;
            sel_o   <= '0;
            mask_r  <= '0;
            dat_r   <= '0;
            ack_cnt <= '0;
        end else begin
            go_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty && !busy_i) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (issue_mask == '0) begin
                        state <= S_IDLE;
                    end else begin
                        go_o   <= 1'b1;
                        sel_o  <= lowest_set(16'(issue_mask));
                        dat_o  <= issue_dat;
                        dat_r  <= issue_dat;
                        mask_r <= issue_mask & (issue_mask - 1'b1);
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ack_cnt <= '0;
                    state   <= S_ACK;
                end
                // No busy response within the timeout counts as completion.
                S_ACK: begin
                    if (busy_i) begin
                        state <= S_DONE;
                    end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        state <= S_NEXT;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                S_DONE: begin
                    if (!busy_i) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (issue_mask != '0) begin
                        go_o   <= 1'b1;
                        sel_o  <= lowest_set(16'(issue_mask));
                        dat_o  <= issue_dat;
                        mask_r <= issue_mask & (issue_mask - 1'b1);
                        state  <= S_ISSUE;
                    end else if (!fifo_empty) begin
                        state <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab4d_register_sequencer.sv
// Directed bench for the LAB4D register sequencer: a table of single writes
// plus hand-written overflow, ACK timeout and mid-transfer reset sequences.
module tb_lab4d_register_sequencer;

    typedef struct {
        logic [23:0] dat;
        logic [11:0] mask;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wr_i;
    logic [23:0] wr_dat_i;
    logic [11:0] wr_mask_i;
    logic        full_o;
    logic [4:0]  count_o;
    logic        idle_o;
    logic        overflow_o;
    logic        clr_ovf_i;
    logic        go_o;
    logic [23:0] dat_o;
    logic [3:0]  sel_o;
    logic        busy_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Busy model and go monitor state (written only by the monitor process).
    int          busy_cnt = 0;
    logic        prev_go = 1'b0;
    int          mon_viol = 0;
    int          go_cyc_q[$];
    logic [3:0]  go_sel_q[$];
    logic [23:0] go_dat_q[$];

    // Model controls (written only by the stimulus process).
    logic model_en = 1'b1;
    logic busy_force = 1'b0;
    int   busy_len = 3;

    vec_t vecs[6];

    lab4d_register_sequencer #(
        .NUM_LAB    (12),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wr_i       (wr_i),
        .wr_dat_i   (wr_dat_i),
        .wr_mask_i  (wr_mask_i),
        .full_o     (full_o),
        .count_o    (count_o),
        .idle_o     (idle_o),
        .overflow_o (overflow_o),
        .clr_ovf_i  (clr_ovf_i),
        .go_o       (go_o),
        .dat_o      (dat_o),
        .sel_o      (sel_o),
        .busy_i     (busy_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shift register stand-in: busy rises right after go and holds busy_len cycles.
    always @(negedge clk) begin
        if (go_o) begin
            go_cyc_q.push_back(cyc);
            go_sel_q.push_back(sel_o);
            go_dat_q.push_back(dat_o);
            if (prev_go || busy_i) begin
                mon_viol = mon_viol + 1;
                $display("[TB] FAIL go_protocol: go at cycle %0d with prev_go=%0b busy=%0b, required both 0",
                         cyc, prev_go, busy_i);
            end
        end
        prev_go = go_o;
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (go_o && model_en) busy_cnt = busy_len;
        busy_i = busy_force || (busy_cnt > 0);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] dat, input logic [11:0] mask, output int wr_cyc);
        @(negedge clk);
        wr_i      = 1'b1;
        wr_dat_i  = dat;
        wr_mask_i = mask;
        wr_cyc    = cyc;
        @(negedge clk);
        wr_i = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (idle_o) break;
        end
        checkOutput(name, int'(idle_o), 1);
    endtask

    initial begin
        int w;
        int start;
        int n;

        vecs[0] = '{24'h123456, 12'h001, 1, 0, 0};
        vecs[1] = '{24'h0a0b0c, 12'h805, 3, 0, 11};
        vecs[2] = '{24'habcdef, 12'h800, 1, 11, 11};
        vecs[3] = '{24'h555555, 12'hfff, 12, 0, 11};
        vecs[4] = '{24'h000001, 12'h000, 0, 0, 0};
        vecs[5] = '{24'hf0f0f0, 12'h0a0, 2, 5, 7};

        rst_i = 1'b1; wr_i = 1'b0; wr_dat_i = '0; wr_mask_i = '0; clr_ovf_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("reset go", int'(go_o), 0);
        checkOutput("reset dat", int'(dat_o), 0);
        checkOutput("reset sel", int'(sel_o), 0);
        checkOutput("reset full", int'(full_o), 0);
        checkOutput("reset count", int'(count_o), 0);
        checkOutput("reset ovf", int'(overflow_o), 0);
        checkOutput("reset idle", int'(idle_o), 1);

        // Table: single writes with busy held 3 cycles per transfer.
        busy_len = 3;
        for (int v = 0; v < 6; v++) begin
            start = go_cyc_q.size();
            applyStimulus(vecs[v].dat, vecs[v].mask, w);
            waitIdle($sformatf("v%0d idle", v), 300);
            n = go_cyc_q.size() - start;
            checkOutput($sformatf("v%0d go count", v), n, vecs[v].exp_n);
            if (n > 0 && vecs[v].exp_n > 0) begin
                checkOutput($sformatf("v%0d latency", v), go_cyc_q[start] - w, 3);
                checkOutput($sformatf("v%0d first sel", v), int'(go_sel_q[start]), vecs[v].exp_first);
                checkOutput($sformatf("v%0d last sel", v), int'(go_sel_q[start+n-1]), vecs[v].exp_last);
                checkOutput($sformatf("v%0d first dat", v), int'(go_dat_q[start]), int'(vecs[v].dat));
                checkOutput($sformatf("v%0d last dat", v), int'(go_dat_q[start+n-1]), int'(vecs[v].dat));
            end
            if (n > 1) begin
                checkOutput($sformatf("v%0d gap", v), go_cyc_q[start+1] - go_cyc_q[start], busy_len + 2);
            end
            if (v == 1 && n == 3) begin
                checkOutput("v1 mid sel", int'(go_sel_q[start+1]), 2);
            end
        end

        // Burst of 17 writes while busy is forced high: 16 kept, 17th overflows.
        @(negedge clk);
        busy_force = 1'b1;
        @(negedge clk);
        start = go_cyc_q.size();
        for (int i = 0; i < 17; i++) begin
            wr_i = 1'b1; wr_dat_i = 24'(i); wr_mask_i = 12'h001;
            @(negedge clk);
        end
        checkOutput("burst count", int'(count_o), 16);
        checkOutput("burst full", int'(full_o), 1);
        checkOutput("burst ovf", int'(overflow_o), 1);
        wr_dat_i = 24'hdead00; clr_ovf_i = 1'b1;
        @(negedge clk);
        checkOutput("ovf set beats clear", int'(overflow_o), 1);
        wr_i = 1'b0;
        @(negedge clk);
        checkOutput("ovf cleared", int'(overflow_o), 0);
        checkOutput("burst count hold", int'(count_o), 16);
        clr_ovf_i = 1'b0;
        busy_len = 2;
        busy_force = 1'b0;
        waitIdle("burst idle", 2000);
        n = go_cyc_q.size() - start;
        checkOutput("burst go count", n, 16);
        for (int i = 0; i < 16 && i < n; i++) begin
            checkOutput($sformatf("burst dat %0d", i), int'(go_dat_q[start+i]), i);
        end

        // Busy never responds: each transfer completes via the ACK timeout.
        model_en = 1'b0;
        start = go_cyc_q.size();
        applyStimulus(24'h777777, 12'h003, w);
        waitIdle("timeout idle", 300);
        n = go_cyc_q.size() - start;
        checkOutput("timeout go count", n, 2);
        if (n == 2) begin
            checkOutput("timeout latency", go_cyc_q[start] - w, 3);
            checkOutput("timeout sel0", int'(go_sel_q[start]), 0);
            checkOutput("timeout sel1", int'(go_sel_q[start+1]), 1);
            checkOutput("timeout gap", go_cyc_q[start+1] - go_cyc_q[start], 6);
        end

        // Reset while DONE waits on a long busy with three entries queued.
        model_en = 1'b1;
        busy_len = 30;
        applyStimulus(24'h111111, 12'h003, w);
        applyStimulus(24'h222222, 12'h001, w);
        applyStimulus(24'h333333, 12'h001, w);
        applyStimulus(24'h444444, 12'h001, w);
        checkOutput("pre-reset count", int'(count_o), 3);
        checkOutput("pre-reset busy", int'(busy_i), 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        start = go_cyc_q.size();
        checkOutput("post-reset count", int'(count_o), 0);
        checkOutput("post-reset go", int'(go_o), 0);
        checkOutput("post-reset idle", int'(idle_o), 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_i) break;
        end
        checkOutput("busy released", int'(busy_i), 0);
        repeat (6) @(negedge clk);
        checkOutput("no go after reset", go_cyc_q.size() - start, 0);
        checkOutput("idle after reset", int'(idle_o), 1);
        busy_len = 3;
        applyStimulus(24'h0badf0, 12'h004, w);
        waitIdle("recover idle", 300);
        n = go_cyc_q.size() - start;
        checkOutput("recover go count", n, 1);
        if (n == 1) begin
            checkOutput("recover latency", go_cyc_q[start] - w, 3);
            checkOutput("recover sel", int'(go_sel_q[start]), 2);
            checkOutput("recover dat", int'(go_dat_q[start]), 24'h0badf0);
        end

        checkOutput("go protocol violations", mon_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/lab4d_register_sequencer.md
# lab4d_register_sequencer

Upstream feeder for `lab4d_shift_register`. It accepts LAB4D register writes from the control bus, each addressed to any subset of the 12 LAB4Ds by chip mask, and queues them in a FIFO. It expands each mask into per-chip transfers and drives the shift register's go/dat/sel inputs one transfer at a time, pacing on its busy output. Prescale is not handled here; it goes straight to the shift register.

## Interface
- `NUM_LAB`, 12: number of LAB4Ds; `sel_o` indexes 0..NUM_LAB-1.
- `FIFO_DEPTH`, 16: queued write entries; power of 2, ≥2.
- `clk_i` in 1: single clock; all logic is synchronous to it.
- `rst_i` in 1: synchronous, active-high reset.
- `wr_i` in 1: enqueue strobe, one entry per cycle high.
- `wr_dat_i` in 24: LAB4D register word (address and value as the shift register expects).
- `wr_mask_i` in NUM_LAB: target chips; bit n means chip n.
- `full_o` out 1: FIFO holds FIFO_DEPTH entries.
- `count_o` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `idle_o` out 1: FIFO empty, FSM in IDLE, and `busy_i` low.
- `overflow_o` out 1: sticky; set when a write is dropped.
- `clr_ovf_i` in 1: clears `overflow_o`.
- `go_o` out 1: one-cycle start pulse to the shift register.
- `dat_o` out 24: data to the shift register; held stable from `go_o` until the next issue.
- `sel_o` out 4: chip select to the shift register; held like `dat_o`.
- `busy_i` in 1: shift register busy.

## Operation
- FIFO entry = {mask, dat}, 36 bits.
- Write handling:
  - `wr_i` with `full_o` low: entry pushed.
  - `wr_i` with `full_o` high: entry dropped and `overflow_o` set. This applies even if a pop happens the same cycle.
- `clr_ovf_i` and an overflow in the same cycle: set wins.
- FSM states:
  - IDLE: stay while FIFO is empty or `busy_i` is high; otherwise go to LOAD.
  - LOAD: pop the head into `mask_r`/`dat_r`. If the mask is zero, discard it and return to IDLE (no issue). Otherwise go to ISSUE.
  - ISSUE: `sel_o` ← index of the lowest set bit of `mask_r`, `dat_o` ← `dat_r`, `go_o` = 1 for this cycle only; clear that bit in `mask_r`; go to ACK.
  - ACK: wait for `busy_i` high, then go to DONE. If `busy_i` stays low for 4 cycles, treat the transfer as complete and go to NEXT.
  - DONE: wait for `busy_i` low, then go to NEXT.
  - NEXT: if `mask_r` ≠ 0, go to ISSUE. Otherwise go to LOAD if the FIFO is non-empty, else IDLE.
- Chips are issued in ascending index order. Mask bits at or above NUM_LAB are ignored, since they do not exist in the port.
- Writes are accepted in every state. New entries never alter a mask already in flight.

## Timing
- Reset values: `go_o`=0, `dat_o`=0, `sel_o`=0, `full_o`=0, `count_o`=0, `overflow_o`=0, `idle_o`=1 (if `busy_i`=0). FSM resets to IDLE and the FIFO is flushed.
- `count_o` and `full_o` update the cycle after a push or pop.
- Latency with FSM idle and `busy_i` low: `wr_i` at cycle N → `go_o` high at N+3 (N+1 IDLE sees non-empty, N+2 LOAD, N+3 ISSUE).
- Inter-transfer gap: first cycle DONE samples `busy_i` low is M → next `go_o` at M+2 (NEXT, then ISSUE). A chain through LOAD gives M+3.
- `go_o` is never high on two consecutive cycles, and is never asserted while `busy_i` is sampled high.
- Reset mid-transfer: the in-flight shift is not aborted and the remaining mask is lost. IDLE holds until `busy_i` falls, so a new `go_o` cannot collide.

## Structure
- Package `lab4d_pkg`:
  - NUM_LAB default
  - entry width / struct {mask, dat}
  - FSM state enum
  - ACK timeout constant (4)
  - function `lowest_set(mask)` returning a 4-bit index
- Sub-module `lab4d_seq_fifo`: synchronous FWFT FIFO with push, pop, full, count. Push-when-full is ignored inside the FIFO; overflow accounting stays in the parent.

## Test plan
- Single write, `wr_dat_i`=24'h123456, mask=12'h001, busy model high 20 cycles after go → one `go_o` 3 cycles after `wr_i` with `sel_o`=0, `dat_o`=24'h123456; `idle_o` returns high after busy falls.
- Mask 12'h805 → three `go_o` pulses with `sel_o`=0, 2, 11 in order; each `go_o` is 2 cycles after the previous busy falls.
- 17 back-to-back writes while busy is held high → first 16 accepted, `count_o`=16, `full_o`=1, 17th dropped, `overflow_o`=1; `clr_ovf_i` clears it. All 16 later issue in FIFO order.
- Mask 0 followed by mask 12'h002 → no transfer for the first entry; a single `go_o` with `sel_o`=1.
- Busy model that never asserts → each transfer completes via the 4-cycle ACK timeout; the next `go_o` follows with no hang.
- `rst_i` pulsed while DONE waits with `busy_i` high and 3 entries queued → FIFO flushed, `count_o`=0, no `go_o` until `busy_i` falls and a new write arrives.
